// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: RAW stall counter, branch flush, halt parking, D-cache freeze.
// Latency: outputs are combinational from state, cnt and inputs (0 cycles); state and cnt are registered.
// Backpressure: dc_busy freezes the whole pipe and holds state; HAZARD_FORWARD_EN enables bypass-aware stalls.
module hazard_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             id_halt,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_wreg,
    input  logic             mem_regwrite,
    input  logic             br_taken,
    input  logic             dc_busy,
    output logic             stall,
    output logic             nop,
    output logic             flush_ifid,
    output logic             DC_Stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             hitEx, hitMem;
    logic [CNT_W-1:0] needCnt;

    assign hitEx  = ex_regwrite  && ((id_rs_vld && (id_rs == ex_wreg))  || (id_rt_vld && (id_rt == ex_wreg)));
    assign hitMem = mem_regwrite && ((id_rs_vld && (id_rs == mem_wreg)) || (id_rt_vld && (id_rt == mem_wreg)));

`ifdef HAZARD_FORWARD_EN
    // Bypass covers everything except a load whose data is not back until MEM.
    assign needCnt = (hitEx && ex_memread) ? CNT_W'(1) : '0;
`else
    // No bypass: wait for the producer to reach write-back (regfile writes before read).
    assign needCnt = hitEx ? CNT_W'(2) : (hitMem ? CNT_W'(1) : '0);
`endif

    always_comb begin
        stall      = 1'b0;
        nop        = 1'b0;
        flush_ifid = 1'b0;
        DC_Stall   = 1'b0;
        stateNext  = state;
        cntNext    = cnt;
        if (!rst) begin
            if (dc_busy) begin
                DC_Stall = 1'b1;
            end else if (br_taken) begin
                // Anything pending belongs to the wrong path.
                flush_ifid = 1'b1;
                nop        = 1'b1;
                stateNext  = RUN;
                cntNext    = '0;
            end else begin
                case (state)
                    RUN: begin
                        if (needCnt != '0) begin
                            stall = 1'b1;
                            nop   = 1'b1;
                            if (needCnt > CNT_W'(1)) begin
                                stateNext = STALL;
                                cntNext   = needCnt - CNT_W'(1);
                            end
                        end else if (id_halt) begin
                            stateNext = HALTED;
                        end
                    end
                    STALL: begin
                        stall = 1'b1;
                        nop   = 1'b1;
                        if (cnt <= CNT_W'(1)) begin
                            stateNext = RUN;
                            cntNext   = '0;
                        end else begin
                            cntNext = cnt - CNT_W'(1);
                        end
                    end
                    HALTED: begin
                        stall = 1'b1;
                        nop   = 1'b1;
                    end
                    default: begin
                        stateNext = RUN;
                        cntNext   = '0;
                    end
                endcase
            end
        end
    end

    assign stall_cnt = rst ? '0 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: owed-stall-cycles/halt-flag model checked every negedge, plus literal spot checks.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] id_rs, id_rt, ex_wreg, mem_wreg;
    logic       id_rs_vld, id_rt_vld, id_halt, ex_regwrite, ex_memread, mem_regwrite, br_taken, dc_busy;
    logic       stall, nop, flush_ifid, DC_Stall;
    logic [1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model: cycles of RAW stall still owed after this one, and whether the front end is parked.
    int mRem  = 0;
    bit mHalt = 0;

    hazard_ctrl #(.REG_W(3), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld), .id_halt(id_halt),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
        .br_taken(br_taken), .dc_busy(dc_busy),
        .stall(stall), .nop(nop), .flush_ifid(flush_ifid), .DC_Stall(DC_Stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (stall,nop,flush,dc,cnt) at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [2:0] r);
        return (id_rs_vld && id_rs == r) || (id_rt_vld && id_rt == r);
    endfunction

    function automatic int need();
        bit hitEx  = ex_regwrite && reads(ex_wreg);
        bit hitMem = mem_regwrite && reads(mem_wreg);
`ifdef HAZARD_FORWARD_EN
        return (hitEx && ex_memread) ? 1 : 0;
`else
        return hitEx ? 2 : (hitMem ? 1 : 0);
`endif
    endfunction

    // o = {stall, nop, flush_ifid, DC_Stall, stall_cnt}
    function automatic void evalModel(output logic [5:0] o, output int nRem, output bit nHalt);
        o     = '0;
        nRem  = mRem;
        nHalt = mHalt;
        if (rst) begin
            nRem  = 0;
            nHalt = 0;
        end else if (dc_busy) begin
            o = {4'b0001, 2'(mRem)};
        end else if (br_taken) begin
            o     = {4'b0110, 2'(mRem)};
            nRem  = 0;
            nHalt = 0;
        end else if (mRem > 0) begin
            o    = {4'b1100, 2'(mRem)};
            nRem = mRem - 1;
        end else if (mHalt) begin
            o = 6'b110000;
        end else begin
            int n = need();
            if (n > 0) begin
                o    = 6'b110000;
                nRem = n - 1;
            end else if (id_halt) begin
                nHalt = 1;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [5:0] o;
        int         r;
        bit         h;
        evalModel(o, r, h);
        mRem  = r;
        mHalt = h;
    end

    always @(negedge clk) begin
        logic [5:0] o;
        int         r;
        bit         h;
        evalModel(o, r, h);
        chk("cycle", {26'd0, stall, nop, flush_ifid, DC_Stall, stall_cnt}, {26'd0, o});
    end

    task automatic lit(input string name, input logic s, input logic n, input logic f, input logic d, input logic [1:0] c);
        chk(name, {26'd0, stall, nop, flush_ifid, DC_Stall, stall_cnt}, {26'd0, s, n, f, d, c});
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_rs_vld = 0; id_rt_vld = 0; id_halt = 0;
        ex_wreg = '0; ex_regwrite = 0; ex_memread = 0;
        mem_wreg = '0; mem_regwrite = 0; br_taken = 0; dc_busy = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    initial begin
        idle();
        dc_busy = 1; br_taken = 1;
        #2 lit("reset", 0, 0, 0, 0, 2'd0);
        tick(); tick();
        rst = 0; idle();
        #2 lit("idle", 0, 0, 0, 0, 2'd0);
        tick();

        // ALU producer in EX, then MEM, then gone
        id_rs = 3'd1; id_rs_vld = 1; ex_wreg = 3'd1; ex_regwrite = 1;
        #2 lit("raw_ex_c1", !FWD, !FWD, 0, 0, 2'd0);
        tick();
        ex_regwrite = 0; mem_wreg = 3'd1; mem_regwrite = 1;
        #2 lit("raw_ex_c2", !FWD, !FWD, 0, 0, FWD ? 2'd0 : 2'd1);
        tick();
        mem_regwrite = 0;
        #2 lit("raw_ex_c3", 0, 0, 0, 0, 2'd0);
        tick();

        // load-use on rt
        idle(); id_rt = 3'd2; id_rt_vld = 1; ex_wreg = 3'd2; ex_regwrite = 1; ex_memread = 1;
        #2 lit("ld_use_c1", 1, 1, 0, 0, 2'd0);
        tick();
        ex_regwrite = 0; ex_memread = 0; mem_wreg = 3'd2; mem_regwrite = 1;
        #2 lit("ld_use_c2", !FWD, !FWD, 0, 0, FWD ? 2'd0 : 2'd1);
        tick();
        idle();
        #2 lit("ld_use_c3", 0, 0, 0, 0, 2'd0);
        tick();

        // MEM-only hit on R0, then an unread match
        id_rs = 3'd0; id_rs_vld = 1; mem_wreg = 3'd0; mem_regwrite = 1;
        #2 lit("raw_mem_r0", !FWD, !FWD, 0, 0, 2'd0);
        tick();
        idle(); id_rs = 3'd5; ex_wreg = 3'd5; ex_regwrite = 1;
        #2 lit("no_vld", 0, 0, 0, 0, 2'd0);
        tick();

        // cache miss while one stall cycle is still owed; br_taken ignored under dc_busy
        idle(); id_rs = 3'd4; id_rs_vld = 1; ex_wreg = 3'd4; ex_regwrite = 1;
        tick();
        idle(); dc_busy = 1;
        for (int i = 0; i < 4; i++) begin
            br_taken = (i == 2);
            #2 lit("dc_hold", 0, 0, 0, 1, FWD ? 2'd0 : 2'd1);
            tick();
        end
        dc_busy = 0; br_taken = 0;
        #2 lit("dc_after", !FWD, !FWD, 0, 0, FWD ? 2'd0 : 2'd1);
        tick();
        #2 lit("dc_done", 0, 0, 0, 0, 2'd0);
        tick();

        // taken branch while stalled
        id_rs = 3'd6; id_rs_vld = 1; ex_wreg = 3'd6; ex_regwrite = 1;
        tick();
        idle(); br_taken = 1;
        #2 lit("br_in_stall", 0, 1, 1, 0, FWD ? 2'd0 : 2'd1);
        tick();
        idle();
        #2 lit("br_after", 0, 0, 0, 0, 2'd0);
        tick();

        // halt parking
        id_halt = 1;
        #2 lit("halt_pass", 0, 0, 0, 0, 2'd0);
        tick();
        id_halt = 0;
        for (int i = 0; i < 12; i++) begin
            id_rs = 3'(i); id_rs_vld = 1; ex_wreg = 3'(i); ex_regwrite = (i == 5);
            #2 lit("halted", 1, 1, 0, 0, 2'd0);
            tick();
        end
        idle(); dc_busy = 1;
        #2 lit("halt_dc", 0, 0, 0, 1, 2'd0);
        tick();
        dc_busy = 0; br_taken = 1;
        #2 lit("halt_br", 0, 1, 1, 0, 2'd0);
        tick();
        br_taken = 0;
        #2 lit("halt_rel", 0, 0, 0, 0, 2'd0);
        tick();

        // halt blocked by a load-use hazard
        id_halt = 1; id_rs = 3'd3; id_rs_vld = 1; ex_wreg = 3'd3; ex_regwrite = 1; ex_memread = 1;
        #2 lit("halt_haz", 1, 1, 0, 0, 2'd0);
        tick();
        idle();
        #2 lit("halt_haz2", !FWD, !FWD, 0, 0, FWD ? 2'd0 : 2'd1);
        tick();
        #2 lit("halt_haz3", 0, 0, 0, 0, 2'd0);
        tick();

        // reset in the middle of a stall and a miss
        id_rs = 3'd7; id_rs_vld = 1; ex_wreg = 3'd7; ex_regwrite = 1; ex_memread = 1;
        tick();
        idle(); rst = 1; dc_busy = 1;
        #2 lit("rst_mid", 0, 0, 0, 0, 2'd0);
        tick();
        rst = 0; dc_busy = 0;
        #2 lit("rst_after", 0, 0, 0, 0, 2'd0);
        tick();

        // mixed traffic, model-checked only
        for (int i = 0; i < 80; i++) begin
            id_rs = 3'($urandom_range(0, 7)); id_rt = 3'($urandom_range(0, 7));
            id_rs_vld = 1'($urandom_range(0, 1)); id_rt_vld = 1'($urandom_range(0, 1));
            ex_wreg = 3'($urandom_range(0, 7)); mem_wreg = 3'($urandom_range(0, 7));
            ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            id_halt = ($urandom_range(0, 9) == 0);
            br_taken = ($urandom_range(0, 5) == 0);
            dc_busy = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
